// File: rtl/display_timing_480p_pkg.sv
// Shared display definitions: 640x480 timing constants, line/frame total helper
// and the coordinate type used throughout the pixel pipeline.
package display_timing_480p_pkg;

    localparam int CORDW  = 10;

    localparam int H_RES  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    localparam int V_RES  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    // Total period of one axis: visible region plus both porches and the sync pulse.
    function automatic int axis_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = axis_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_RES, V_FP, V_SYNC, V_BP);

    typedef logic [CORDW-1:0] coord_t;

endpackage

// File: rtl/display_timing_480p.sv
// Video timing generator: pixel position counters plus one registered output stage,
// held idle (and restarted from the top-left pixel) whenever the pixel PLL is unlocked.
module display_timing_480p #(
    parameter int   CORDW  = display_timing_480p_pkg::CORDW,
    parameter int   H_RES  = display_timing_480p_pkg::H_RES,
    parameter int   H_FP   = display_timing_480p_pkg::H_FP,
    parameter int   H_SYNC = display_timing_480p_pkg::H_SYNC,
    parameter int   H_BP   = display_timing_480p_pkg::H_BP,
    parameter int   V_RES  = display_timing_480p_pkg::V_RES,
    parameter int   V_FP   = display_timing_480p_pkg::V_FP,
    parameter int   V_SYNC = display_timing_480p_pkg::V_SYNC,
    parameter int   V_BP   = display_timing_480p_pkg::V_BP,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0,
    parameter int   FCW    = 16
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             clk_pix_locked,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic             line,
    output logic [FCW-1:0]   frame_cnt
);
    import display_timing_480p_pkg::*;

    localparam int H_TOTAL = axis_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_RES, V_FP, V_SYNC, V_BP);

    if ((2**CORDW) < H_TOTAL || (2**CORDW) < V_TOTAL) begin : g_cordw_too_small
        $error("CORDW too narrow for the configured line/frame totals");
    end

    // Region boundaries pre-sized to the counter width so comparisons stay width-matched.
    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACTIVE = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACTIVE = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

    logic [CORDW-1:0] h_reg, v_reg;
    logic [CORDW-1:0] h_next, v_next;
    logic             de_next, hsync_next, vsync_next, line_next, frame_next;

    always_comb begin
        h_next     = h_reg + 1'b1;
        v_next     = v_reg;
        if (h_reg == H_LAST) begin
            h_next = '0;
            v_next = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
        end
        de_next    = (h_reg < H_ACTIVE) && (v_reg < V_ACTIVE);
        hsync_next = (h_reg >= HS_START && h_reg < HS_END) ? H_POL : ~H_POL;
        vsync_next = (v_reg >= VS_START && v_reg < VS_END) ? V_POL : ~V_POL;
        line_next  = (h_reg == '0);
        frame_next = (h_reg == '0) && (v_reg == '0);
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            h_reg     <= '0;
            v_reg     <= '0;
            sx        <= '0;
            sy        <= '0;
            de        <= 1'b0;
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            line      <= 1'b0;
            frame     <= 1'b0;
            frame_cnt <= '0;
        end else if (!clk_pix_locked) begin
            // Abandon any partial frame; frame_cnt keeps its value across the outage.
            h_reg     <= '0;
            v_reg     <= '0;
            sx        <= '0;
            sy        <= '0;
            de        <= 1'b0;
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            line      <= 1'b0;
            frame     <= 1'b0;
        end else begin
            h_reg     <= h_next;
            v_reg     <= v_next;
            sx        <= h_reg;
            sy        <= v_reg;
            de        <= de_next;
            hsync     <= hsync_next;
            vsync     <= vsync_next;
            line      <= line_next;
            frame     <= frame_next;
            if (frame_next) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule
